// File: rtl/store_checker.sv
// rtl/store_checker.sv - monitors processor stores and reports pass, fail or timeout of a test run
module store_checker #(
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd25,
    parameter logic [31:0] SCRATCH_ADR = 32'd96,
    parameter logic [31:0] STATUS_ADR  = 32'd104,
    parameter logic [31:0] TIMEOUT     = 32'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        En,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Pass,
    output logic        Fail,
    output logic        Timeout,
    output logic [15:0] StoreCount,
    output logic [31:0] FailAdr,
    output logic [31:0] FailData
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        RUN  = 4'd1,
        PASS = 4'd2,
        FAIL = 4'd3,
        TOUT = 4'd4
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] cycleCount;
    logic        runStore;
    logic        enterFail;

    assign runStore  = (state == RUN) && MemWrite;
    assign enterFail = (state == RUN) && (nextState == FAIL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A terminating store outranks the timeout; scratch stores do not hold it off.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (En) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (MemWrite && (DataAdr == PASS_ADR)) begin
                    nextState = (WriteData == PASS_DATA) ? PASS : FAIL;
                end else if (MemWrite && (DataAdr != SCRATCH_ADR)) begin
                    nextState = FAIL;
                end else if (cycleCount == (TIMEOUT - 32'd1)) begin
                    nextState = TOUT;
                end
            end
            default: nextState = state;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycleCount <= 32'd0;
            StoreCount <= 16'd0;
            FailAdr    <= 32'd0;
            FailData   <= 32'd0;
            Pass       <= 1'b0;
            Fail       <= 1'b0;
            Timeout    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            if ((state == IDLE) && En) begin
                cycleCount <= 32'd0;
            end else if (state == RUN) begin
                cycleCount <= cycleCount + 32'd1;
            end
            if (runStore && (StoreCount != 16'hFFFF)) begin
                StoreCount <= StoreCount + 16'd1;
            end
            if (enterFail) begin
                FailAdr  <= DataAdr;
                FailData <= WriteData;
            end
            Pass    <= (nextState == PASS);
            Fail    <= (nextState == FAIL);
            Timeout <= (nextState == TOUT);
            Done    <= (nextState == PASS) || (nextState == FAIL) || (nextState == TOUT);
        end
    end

    assign ReadData = (DataAdr == STATUS_ADR) ? {StoreCount, 12'b0, 4'(state)} : 32'd0;

endmodule

// File: tb/tb_store_checker.sv
// tb/tb_store_checker.sv - directed bench for store_checker with a cycle-level outcome model
module tb_store_checker;

    localparam logic [31:0] TMO = 32'd50;

    logic        clk = 1'b0;
    logic        reset;
    logic        En;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Done;
    logic        Pass;
    logic        Fail;
    logic        Timeout;
    logic [15:0] StoreCount;
    logic [31:0] FailAdr;
    logic [31:0] FailData;

    int vectors = 0;
    int miscompares = 0;

    store_checker #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .En(En), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(ReadData),
        .Done(Done), .Pass(Pass), .Fail(Fail), .Timeout(Timeout),
        .StoreCount(StoreCount), .FailAdr(FailAdr), .FailData(FailData)
    );

    always #5 clk = ~clk;

    // Outcome model: 0 idle, 1 running, 2 passed, 3 failed, 4 timed out
    logic [3:0]  mOutcome = 4'd0;
    int unsigned mElapsed = 0;
    logic [15:0] mStores = 16'd0;
    logic [31:0] mFailAdr = 32'd0;
    logic [31:0] mFailData = 32'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mOutcome  = 4'd0;
            mElapsed  = 0;
            mStores   = 16'd0;
            mFailAdr  = 32'd0;
            mFailData = 32'd0;
        end else if (mOutcome == 4'd0) begin
            if (En) begin
                mOutcome = 4'd1;
                mElapsed = 0;
            end
        end else if (mOutcome == 4'd1) begin
            mElapsed++;
            if (MemWrite) begin
                if (mStores != 16'hFFFF) mStores++;
                if (DataAdr == 32'd100) mOutcome = (WriteData == 32'd25) ? 4'd2 : 4'd3;
                else if (DataAdr != 32'd96) mOutcome = 4'd3;
                if (mOutcome == 4'd3) begin
                    mFailAdr  = DataAdr;
                    mFailData = WriteData;
                end
            end
            if (mOutcome == 4'd1 && mElapsed == TMO) mOutcome = 4'd4;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        check("Pass", 32'(Pass), 32'(mOutcome == 4'd2));
        check("Fail", 32'(Fail), 32'(mOutcome == 4'd3));
        check("Timeout", 32'(Timeout), 32'(mOutcome == 4'd4));
        check("Done", 32'(Done), 32'(mOutcome >= 4'd2));
        check("StoreCount", 32'(StoreCount), 32'(mStores));
        check("FailAdr", FailAdr, mFailAdr);
        check("FailData", FailData, mFailData);
        check("ReadData", ReadData, (DataAdr == 32'd104) ? {mStores, 12'b0, mOutcome} : 32'd0);
    end

    task automatic cyc(input logic en, input logic mw, input logic [31:0] adr, input logic [31:0] wd);
        En = en;
        MemWrite = mw;
        DataAdr = adr;
        WriteData = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        En = 1'b0;
        MemWrite = 1'b0;
        DataAdr = 32'd104;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        En = 1'b0;
        MemWrite = 1'b0;
        DataAdr = 32'd0;
        WriteData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        DataAdr = 32'd104;
        #1;
        check("reset ReadData", ReadData, 32'd0);
        check("reset Done", 32'(Done), 32'd0);
        reset = 1'b0;

        // IDLE ignores stores, first edge after release accepts En
        cyc(1'b0, 1'b1, 32'd100, 32'd25);
        check("idle store ignored", 32'(Pass), 32'd0);
        cyc(1'b1, 1'b0, 32'd104, 32'd0);
        check("run state code", ReadData, 32'h0000_0001);

        // pass run, then sticky
        cyc(1'b0, 1'b1, 32'd96, 32'd7);
        cyc(1'b0, 1'b1, 32'd100, 32'd25);
        MemWrite = 1'b0;
        DataAdr = 32'd104;
        #1;
        check("pass Pass", 32'(Pass), 32'd1);
        check("pass status", ReadData, 32'h0002_0002);
        cyc(1'b1, 1'b1, 32'd108, 32'd0);
        check("sticky Fail", 32'(Fail), 32'd0);
        check("sticky count", 32'(StoreCount), 32'd2);

        // illegal address
        doReset();
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 32'd108, 32'd25);
        check("illegal FailAdr", FailAdr, 32'd108);
        check("illegal FailData", FailData, 32'd25);
        check("illegal Done", 32'(Done), 32'd1);
        check("illegal count", 32'(StoreCount), 32'd1);

        // wrong pass data
        doReset();
        check("reset FailAdr", FailAdr, 32'd0);
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 32'd96, 32'd3);
        cyc(1'b0, 1'b1, 32'd100, 32'd24);
        check("wrongdata FailData", FailData, 32'd24);
        check("wrongdata Pass", 32'(Pass), 32'd0);

        // store to the status word is illegal
        doReset();
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 32'd104, 32'd5);
        check("status store Fail", 32'(Fail), 32'd1);
        check("status store code", ReadData, 32'h0001_0003);

        // timeout lands exactly TMO cycles after RUN entry
        doReset();
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i < 50; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
        check("timeout early", 32'(Timeout), 32'd0);
        cyc(1'b0, 1'b0, 32'd104, 32'd0);
        check("timeout edge", 32'(Timeout), 32'd1);
        check("timeout status", ReadData, 32'h0000_0004);

        // store decision beats timeout in the same cycle
        doReset();
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i < 50; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 32'd100, 32'd25);
        check("collision Pass", 32'(Pass), 32'd1);
        check("collision Timeout", 32'(Timeout), 32'd0);
        cyc(1'b0, 1'b0, 32'd0, 32'd0);

        // reset between edges mid-run
        doReset();
        cyc(1'b1, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'd96, 32'(i));
        check("midrun count", 32'(StoreCount), 32'd3);
        MemWrite = 1'b0;
        DataAdr = 32'd104;
        reset = 1'b1;
        #1;
        check("async reset status", ReadData, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b1, 32'd100, 32'd25);
        check("post reset Pass", 32'(Pass), 32'd0);
        cyc(1'b0, 1'b0, 32'd104, 32'd0);
        check("post reset idle", ReadData, 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
